sram_read_shifter: RTL and testbench
====================================

SRAM_READ_SHIFTER -- requirements
Module: sram_read_shifter

Interface
REQ-001 SHALL have parameter DATA_W, default 8, the SRAM data width and the number of serial bits per read.
REQ-002 SHALL have parameter ACCESS_CYCLES, default 2, the clocks CE/OE are held low before data is captured; legal range 1..15.
REQ-003 SHALL have port avr_clk  input  1  block clock; all state changes on its rising edge.
REQ-004 SHALL have port avr_rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port rd_req  input  1  start one SRAM read; sampled only in IDLE.
REQ-006 SHALL have port shift_en  input  1  advance serial output by one bit; sampled only in SHIFT.
REQ-007 SHALL have port sram_data  input  DATA_W  SRAM read data.
REQ-008 SHALL have port sram_ce_n  output  1  SRAM chip enable, active-low.
REQ-009 SHALL have port sram_oe_n  output  1  SRAM output enable, active-low.
REQ-010 SHALL have port avr_so  output  1  serial data to AVR, MSB first.
REQ-011 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-012 SHALL have port done  output  1  one-cycle pulse after the last bit is consumed.
REQ-013 SHALL have port addr_inc  output  1  one-cycle pulse, coincident with done, for the address register to post-increment.

Function
REQ-014 SHALL implement states IDLE, ACCESS, SHIFT, DONE; all outputs registered.
REQ-015 IDLE: rd_req=1 SHALL move to ACCESS next cycle, loading wait counter with ACCESS_CYCLES-1.
REQ-016 ACCESS: sram_ce_n and sram_oe_n SHALL be 0; counter decrements each cycle.
REQ-017 ACCESS with counter=0 SHALL capture sram_data into shift register, load bit counter with DATA_W-1, deassert CE/OE (both 1) and enter SHIFT on the same edge.
REQ-018 Capture-to-CE-high: CE/OE SHALL be low for exactly ACCESS_CYCLES clocks per read.
REQ-019 SHIFT: avr_so SHALL equal shift-register MSB; avr_so valid from the first SHIFT cycle.
REQ-020 SHIFT with shift_en=1 and bit counter>0 SHALL shift left by one (LSB filled 0) and decrement bit counter.
REQ-021 SHIFT with shift_en=1 and bit counter=0 SHALL enter DONE; shift_en=0 SHALL hold all state indefinitely.
REQ-022 DONE SHALL last one cycle with done=1 and addr_inc=1, then return to IDLE.
REQ-023 Total latency rd_req to first valid avr_so SHALL be ACCESS_CYCLES+1 clocks.
REQ-024 rd_req while busy=1 SHALL be ignored (no queuing); rd_req held high in DONE's following IDLE cycle SHALL start a new read.
REQ-025 shift_en in IDLE, ACCESS or DONE SHALL be ignored; simultaneous rd_req and shift_en in IDLE SHALL start a read only.
REQ-026 avr_so SHALL be 0 in IDLE, ACCESS and DONE.
REQ-027 Exactly DATA_W shift_en pulses SHALL be consumed per read; sram_data changes outside the capture edge SHALL have no effect.

Reset
REQ-028 avr_rst=1 SHALL immediately force IDLE, sram_ce_n=1, sram_oe_n=1, avr_so=0, busy=0, done=0, addr_inc=0, counters and shift register 0.
REQ-029 Reset asserted mid-ACCESS or mid-SHIFT SHALL abort the read without done/addr_inc pulse.
REQ-030 First rd_req SHALL be honoured on the first rising edge after avr_rst deasserts.

Verification
REQ-031 Basic read: sram_data=0xA5, rd_req 1 cycle, 8 shift_en -> CE/OE low 2 clocks, avr_so sequence 1,0,1,0,0,1,0,1, then done=addr_inc=1 one cycle, busy=0.
REQ-032 Stalled shift: sram_data=0x80, shift_en gaps of 5 cycles -> avr_so holds 1 during first gap, then 0; done only after 8th shift_en.
REQ-033 Busy rejection: rd_req pulsed during ACCESS and SHIFT -> no second CE/OE assertion; single done.
REQ-034 Back-to-back: rd_req held high, sram_data 0x3C then 0xC3 -> two reads, one IDLE cycle between DONE and next ACCESS, two done pulses.
REQ-035 Reset mid-shift: avr_rst after 3 shift_en -> outputs at reset values same cycle, no done, next read of 0xFF yields eight 1s.
REQ-036 ACCESS_CYCLES=1 build: CE/OE low exactly 1 clock, first avr_so valid 2 clocks after rd_req.

Source files
------------

// File: rtl/sram_read_shifter.sv
// sram_read_shifter
//   Reads one word from an asynchronous SRAM and shifts it out serially, MSB first.
//   IDLE -> ACCESS holds CE/OE low for ACCESS_CYCLES clocks. The last ACCESS edge
//   captures sram_data. SHIFT then advances one bit per shift_en. DONE pulses
//   done/addr_inc for a single cycle before the FSM returns to IDLE.
//
// Parameters
//   DATA_W         SRAM data width and number of serial bits per read (>= 1).
//   ACCESS_CYCLES  clocks CE/OE are held low before capture (1..15).
//
// Ports
//   avr_clk    in   block clock, rising edge
//   avr_rst    in   asynchronous active-high reset
//   rd_req     in   start a read (sampled only in IDLE)
//   shift_en   in   consume one serial bit (sampled only in SHIFT)
//   sram_data  in   SRAM read data
//   sram_ce_n  out  SRAM chip enable, active-low
//   sram_oe_n  out  SRAM output enable, active-low
//   avr_so     out  serial data, MSB first, 0 outside SHIFT
//   busy       out  high whenever not in IDLE
//   done       out  one-cycle pulse after the last bit is consumed
//   addr_inc   out  one-cycle pulse coincident with done
module sram_read_shifter #(
  parameter int unsigned DATA_W        = 8,
  parameter int unsigned ACCESS_CYCLES = 2
) (
  input  logic              avr_clk,
  input  logic              avr_rst,
  input  logic              rd_req,
  input  logic              shift_en,
  input  logic [DATA_W-1:0] sram_data,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              avr_so,
  output logic              busy,
  output logic              done,
  output logic              addr_inc
);

  localparam int unsigned BitCntW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StShift,
    StDone
  } state_e;

  state_e              state_q, state_d;
  logic [3:0]          wait_q, wait_d;
  logic [BitCntW-1:0]  bit_q, bit_d;
  logic [DATA_W-1:0]   sreg_q, sreg_d;

  logic ce_n_q, ce_n_d;
  logic oe_n_q, oe_n_d;
  logic so_q, so_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic inc_q, inc_d;

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    bit_d   = bit_q;
    sreg_d  = sreg_q;

    unique case (state_q)
      StIdle: begin
        if (rd_req) begin
          state_d = StAccess;
          wait_d  = 4'(ACCESS_CYCLES - 1);
        end
      end
      StAccess: begin
        if (wait_q == 4'd0) begin
          sreg_d  = sram_data;
          bit_d   = BitCntW'(DATA_W - 1);
          state_d = StShift;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      StShift: begin
        if (shift_en) begin
          if (bit_q == '0) begin
            state_d = StDone;
          end else begin
            sreg_d = sreg_q << 1;
            bit_d  = bit_q - BitCntW'(1);
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Outputs are decoded from the next state so that they are registered
    // yet line up with the state they describe.
    ce_n_d = (state_d != StAccess);
    oe_n_d = (state_d != StAccess);
    so_d   = (state_d == StShift) && sreg_d[DATA_W-1];
    busy_d = (state_d != StIdle);
    done_d = (state_d == StDone);
    inc_d  = (state_d == StDone);
  end

  always_ff @(posedge avr_clk or posedge avr_rst) begin
    if (avr_rst) begin
      state_q <= StIdle;
      wait_q  <= '0;
      bit_q   <= '0;
      sreg_q  <= '0;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      so_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      inc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      bit_q   <= bit_d;
      sreg_q  <= sreg_d;
      ce_n_q  <= ce_n_d;
      oe_n_q  <= oe_n_d;
      so_q    <= so_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      inc_q   <= inc_d;
    end
  end

  assign sram_ce_n = ce_n_q;
  assign sram_oe_n = oe_n_q;
  assign avr_so    = so_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign addr_inc  = inc_q;

endmodule

// File: tb/tb_sram_read_shifter.sv
// Directed bench for sram_read_shifter: a per-cycle vector table for the basic
// read plus hand-written sequences for stalls, busy rejection, back-to-back
// reads, reset abort and an ACCESS_CYCLES=1 instance.
module tb_sram_read_shifter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rd_req = 1'b0;
  logic       rd1 = 1'b0;
  logic       shift_en = 1'b0;
  logic [7:0] sram_data = 8'h00;

  logic ce_n, oe_n, so, busy, done, ai;
  logic ce_n1, oe_n1, so1, busy1, done1, ai1;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int ce_cnt = 0;
  int ce1_cnt = 0;
  logic [15:0] cap;

  always #5 clk = ~clk;

  sram_read_shifter #(.DATA_W(8), .ACCESS_CYCLES(2)) dut (
    .avr_clk  (clk),
    .avr_rst  (rst),
    .rd_req   (rd_req),
    .shift_en (shift_en),
    .sram_data(sram_data),
    .sram_ce_n(ce_n),
    .sram_oe_n(oe_n),
    .avr_so   (so),
    .busy     (busy),
    .done     (done),
    .addr_inc (ai)
  );

  sram_read_shifter #(.DATA_W(8), .ACCESS_CYCLES(1)) dut1 (
    .avr_clk  (clk),
    .avr_rst  (rst),
    .rd_req   (rd1),
    .shift_en (shift_en),
    .sram_data(sram_data),
    .sram_ce_n(ce_n1),
    .sram_oe_n(oe_n1),
    .avr_so   (so1),
    .busy     (busy1),
    .done     (done1),
    .addr_inc (ai1)
  );

  typedef struct {
    logic       rd;
    logic       se;
    logic [7:0] data;
    logic       ce_n;
    logic       oe_n;
    logic       so;
    logic       busy;
    logic       done;
    logic       ai;
  } vec_t;

  vec_t vecs[12];

  function automatic vec_t mk(input logic r, input logic s, input logic [7:0] d,
                              input logic c, input logic o, input logic q,
                              input logic b, input logic dn, input logic a);
    vec_t v;
    v.rd = r; v.se = s; v.data = d;
    v.ce_n = c; v.oe_n = o; v.so = q; v.busy = b; v.done = dn; v.ai = a;
    return v;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive inputs, take one clock, sample 1 time unit after the edge.
  task automatic step(input logic r, input logic s, input logic [7:0] d);
    rd_req    = r;
    shift_en  = s;
    sram_data = d;
    @(posedge clk);
    #1;
    if (done) done_cnt++;
    if (!ce_n) ce_cnt++;
    if (!ce_n1) ce1_cnt++;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " ce_n"}, ce_n, 1'b1);
    chk({tag, " oe_n"}, oe_n, 1'b1);
    chk({tag, " so"}, so, 1'b0);
    chk({tag, " busy"}, busy, 1'b0);
    chk({tag, " done"}, done, 1'b0);
    chk({tag, " addr_inc"}, ai, 1'b0);
  endtask

  initial begin
    // Basic read of 0xA5; sram_data differs away from the capture edge.
    vecs[0]  = mk(1, 1, 8'hFF, 0, 0, 0, 1, 0, 0);
    vecs[1]  = mk(1, 1, 8'h00, 0, 0, 0, 1, 0, 0);
    vecs[2]  = mk(0, 0, 8'hA5, 1, 1, 1, 1, 0, 0);
    vecs[3]  = mk(0, 1, 8'h5A, 1, 1, 0, 1, 0, 0);
    vecs[4]  = mk(0, 1, 8'h5A, 1, 1, 1, 1, 0, 0);
    vecs[5]  = mk(0, 1, 8'h5A, 1, 1, 0, 1, 0, 0);
    vecs[6]  = mk(0, 1, 8'h5A, 1, 1, 0, 1, 0, 0);
    vecs[7]  = mk(0, 1, 8'h5A, 1, 1, 1, 1, 0, 0);
    vecs[8]  = mk(0, 1, 8'h5A, 1, 1, 0, 1, 0, 0);
    vecs[9]  = mk(0, 1, 8'h5A, 1, 1, 1, 1, 0, 0);
    vecs[10] = mk(0, 1, 8'h5A, 1, 1, 0, 1, 1, 1);
    vecs[11] = mk(0, 0, 8'h5A, 1, 1, 0, 0, 0, 0);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    chk("reset dut1 ce_n", ce_n1, 1'b1);
    chk("reset dut1 busy", busy1, 1'b0);
    rst = 1'b0;

    // Basic read from the table
    for (int i = 0; i < 12; i++) begin
      step(vecs[i].rd, vecs[i].se, vecs[i].data);
      chk($sformatf("v%0d ce_n", i), ce_n, vecs[i].ce_n);
      chk($sformatf("v%0d oe_n", i), oe_n, vecs[i].oe_n);
      chk($sformatf("v%0d so", i), so, vecs[i].so);
      chk($sformatf("v%0d busy", i), busy, vecs[i].busy);
      chk($sformatf("v%0d done", i), done, vecs[i].done);
      chk($sformatf("v%0d addr_inc", i), ai, vecs[i].ai);
    end

    // Stalled shift of 0x80 with 5-cycle gaps
    done_cnt = 0;
    step(1, 0, 8'h80);
    step(0, 0, 8'h80);
    step(0, 0, 8'h80);
    for (int k = 0; k < 8; k++) begin
      for (int j = 0; j < 5; j++) begin
        step(0, 0, 8'h00);
        chk($sformatf("stall k%0d j%0d so", k, j), so, (k == 0) ? 1'b1 : 1'b0);
      end
      chk($sformatf("stall k%0d done early", k), done, 1'b0);
      step(0, 1, 8'h00);
      chk($sformatf("stall k%0d done", k), done, (k == 7) ? 1'b1 : 1'b0);
    end
    step(0, 0, 8'h00);
    chk("stall done count", 16'(done_cnt), 16'd1);
    chk("stall busy end", busy, 1'b0);

    // rd_req pulsed during ACCESS and SHIFT is ignored
    done_cnt = 0;
    ce_cnt   = 0;
    step(1, 0, 8'h33);
    step(1, 0, 8'h33);
    step(1, 0, 8'h33);
    for (int k = 0; k < 8; k++) step((k < 3) ? 1'b1 : 1'b0, 1, 8'h33);
    for (int k = 0; k < 4; k++) step(0, 0, 8'h33);
    chk("busyrej ce low clocks", 16'(ce_cnt), 16'd2);
    chk("busyrej done count", 16'(done_cnt), 16'd1);
    chk("busyrej busy end", busy, 1'b0);

    // Back-to-back reads with rd_req and shift_en held high
    done_cnt = 0;
    ce_cnt   = 0;
    cap      = '0;
    for (int i = 0; i < 24; i++) begin
      step(1, 1, (i <= 11) ? 8'h3C : 8'hC3);
      if (busy && ce_n && !done) cap = {cap[14:0], so};
      if (i == 11) chk("b2b idle gap busy", busy, 1'b0);
      if (i == 12) chk("b2b second access ce_n", ce_n, 1'b0);
    end
    step(0, 0, 8'h00);
    chk("b2b serial bits", cap, 16'h3CC3);
    chk("b2b done count", 16'(done_cnt), 16'd2);
    chk("b2b ce low clocks", 16'(ce_cnt), 16'd4);
    chk("b2b busy end", busy, 1'b0);

    // ACCESS_CYCLES=1 instance
    ce1_cnt = 0;
    rd1 = 1'b1;
    step(0, 0, 8'h80);
    rd1 = 1'b0;
    chk("ac1 ce_n in access", ce_n1, 1'b0);
    chk("ac1 busy", busy1, 1'b1);
    step(0, 0, 8'h80);
    chk("ac1 ce_n after", ce_n1, 1'b1);
    chk("ac1 first so", so1, 1'b1);
    for (int k = 0; k < 8; k++) begin
      step(0, 1, 8'h00);
      if (k == 0) chk("ac1 so after shift", so1, 1'b0);
      chk($sformatf("ac1 k%0d done", k), done1, (k == 7) ? 1'b1 : 1'b0);
    end
    step(0, 0, 8'h00);
    chk("ac1 ce low clocks", 16'(ce1_cnt), 16'd1);
    chk("ac1 busy end", busy1, 1'b0);
    chk("ac1 main dut ignored shift_en", busy, 1'b0);

    // Reset mid-shift aborts, next read of 0xFF is all ones
    done_cnt = 0;
    step(1, 0, 8'h5A);
    step(0, 0, 8'h5A);
    step(0, 0, 8'h5A);
    for (int k = 0; k < 3; k++) step(0, 1, 8'h00);
    chk("rstmid busy before", busy, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk_reset_vals("rstmid");
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(1, 0, 8'hFF);
    chk("rstmid first rd honoured", ce_n, 1'b0);
    step(0, 0, 8'hFF);
    step(0, 0, 8'hFF);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("rstmid bit%0d", k), so, 1'b1);
      step(0, 1, 8'h00);
    end
    chk("rstmid done", done, 1'b1);
    chk("rstmid done count", 16'(done_cnt), 16'd1);
    step(0, 0, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
